// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART_TX request scheduler.
//   sched_state_e   : scheduler FSM encoding (also exported on the debug port)
//   *_DEF           : default values for the scheduler parameters
package uart_sched_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ACK_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req        : per-requester request bits
//   ptr        : highest-priority requester index for this arbitration
//   win_onehot : one-hot winner (all zero when nothing is requested)
//   win_idx    : binary winner index (0 when nothing is requested)
//   any_valid  : at least one request is present
// The priority pointer is owned by the caller; this block holds no state.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_valid
);

  logic [2*NUM_REQ-1:0] req_rot;
  int                   sum;

  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    sum       = 0;
    // Doubling the vector and shifting by ptr puts the requester at ptr
    // in bit 0, so the first set bit upward is the wrap-around winner.
    req_rot   = {req, req} >> ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && req_rot[i]) begin
        any_valid = 1'b1;
        sum       = int'(ptr) + i;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end
        win_idx   = IDX_W'(sum);
      end
    end
    win_onehot = any_valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART_TX between NUM_REQ byte producers.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   REQ, REQ_DATA     : per-requester request level and byte
//   PAR_EN_CFG/TYP    : parity config captured when a frame is issued
//   GNT, DONE, ERR    : one-cycle pulses (accepted / fully sent / no ack)
//   TX_Data_Valid, TX_P_DATA, TX_PAR_EN, TX_PAR_TYP : to UART_TX
//   TX_Busy           : from UART_TX
//   Sched_Busy        : high whenever the FSM is not IDLE
//   dbg_state, dbg_ptr: FSM state and round-robin pointer for observation
//
// Handshake: a requester raises REQ with stable REQ_DATA and holds both
// until it sees its GNT pulse; the byte is committed on the edge that
// produces GNT, and dropping REQ earlier withdraws the request. Towards
// UART_TX, TX_Data_Valid is a one-cycle offer; UART_TX acknowledges by
// raising TX_Busy and signals completion by lowering it again.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic                          PAR_EN_CFG,
  input  logic                          PAR_TYP_CFG,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            DONE,
  output logic                          ERR,
  output logic                          TX_Data_Valid,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  input  logic                          TX_Busy,
  output logic                          Sched_Busy,
  output logic [1:0]                    dbg_state,
  output logic [IDX_W-1:0]              dbg_ptr
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  sched_state_e           state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     arb_onehot;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [DATA_WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (REQ),
    .ptr        (ptr_q),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .any_valid  (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_idx == IDX_W'(k)) begin
        sel_data = REQ_DATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    valid_d   = 1'b0;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    case (state_q)
      IDLE: begin
        // GNT/valid are registered, so they are raised on the edge that
        // enters ISSUE and are visible for exactly the ISSUE cycle.
        if (arb_any && !TX_Busy) begin
          state_d   = ISSUE;
          win_d     = arb_idx;
          ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          data_d    = sel_data;
          par_en_d  = PAR_EN_CFG;
          par_typ_d = PAR_TYP_CFG;
          gnt_d     = arb_onehot;
          valid_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        if (TX_Busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // This is the ACK_TIMEOUT-th WAIT_ACK cycle without Busy.
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!TX_Busy) begin
          state_d = IDLE;
          done_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      busy_q    <= busy_d;
    end
  end

  assign GNT           = gnt_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign TX_Data_Valid = valid_q;
  assign TX_P_DATA     = data_q;
  assign TX_PAR_EN     = par_en_q;
  assign TX_PAR_TYP    = par_typ_q;
  assign Sched_Busy    = busy_q;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios push expected GNT/DONE/ERR
// events (with their exact cycle) into a queue; a monitor pops and compares
// whenever the DUT shows an event. A small UART_TX model drives TX_Busy.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int W  = 33;  // {cyc[15:0], kind[1:0], idx[3:0], valid, pe, pt, data[7:0]}

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] req_data;
  logic           par_en_cfg, par_typ_cfg;
  logic           tx_busy;
  logic           model_busy, force_busy;
  logic [NR-1:0]  gnt, done;
  logic           err, tx_valid, tx_par_en, tx_par_typ, sched_busy;
  logic [DW-1:0]  tx_data;
  logic [1:0]     dbg_state;
  logic [1:0]     dbg_ptr;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int model_mode = 0;  // 0: ack after 1 cycle, busy 11 cycles; 1: never ack
  int busy_len = 11;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_ev, exp_ev;

  assign tx_busy = model_busy | force_busy;

  uart_tx_scheduler dut (
    .CLK           (clk),
    .RST           (rst),
    .REQ           (req),
    .REQ_DATA      (req_data),
    .PAR_EN_CFG    (par_en_cfg),
    .PAR_TYP_CFG   (par_typ_cfg),
    .GNT           (gnt),
    .DONE          (done),
    .ERR           (err),
    .TX_Data_Valid (tx_valid),
    .TX_P_DATA     (tx_data),
    .TX_PAR_EN     (tx_par_en),
    .TX_PAR_TYP    (tx_par_typ),
    .TX_Busy       (tx_busy),
    .Sched_Busy    (sched_busy),
    .dbg_state     (dbg_state),
    .dbg_ptr       (dbg_ptr)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input int c, input logic [1:0] kind, input logic [3:0] idx,
                                      input logic v, input logic pe, input logic pt, input logic [7:0] d);
    return {16'(c), kind, idx, v, pe, pt, d};
  endfunction

  function automatic string ev_str(input logic [W-1:0] e);
    return $sformatf("cyc=%0d kind=%0d idx=%0d v=%0b pe=%0b pt=%0b data=%h",
                     e[32:17], e[16:15], e[14:11], e[10], e[9], e[8], e[7:0]);
  endfunction

  function automatic logic [3:0] oh2idx(input logic [NR-1:0] v);
    int cnt;
    logic [3:0] r;
    cnt = 0;
    r = 4'hF;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        cnt++;
        r = 4'(i);
      end
    end
    return (cnt == 1) ? r : 4'hF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_byte(input int k, input logic [7:0] b);
    for (int j = 0; j < NR; j++) begin
      if (j == k) req_data[j*DW +: DW] = b;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},        32'(gnt), 0);
    check({tag, "_done"},       32'(done), 0);
    check({tag, "_err"},        32'(err), 0);
    check({tag, "_valid"},      32'(tx_valid), 0);
    check({tag, "_data"},       32'(tx_data), 0);
    check({tag, "_par_en"},     32'(tx_par_en), 0);
    check({tag, "_par_typ"},    32'(tx_par_typ), 0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 0);
    check({tag, "_state"},      32'(dbg_state), 0);
    check({tag, "_ptr"},        32'(dbg_ptr), 0);
  endtask

  // Called at a negedge: one reset cycle, then release and check.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    check_reset(tag);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // ---------------- UART_TX model ----------------
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_mode == 0 && tx_valid) begin
        wait_n(1);
        model_busy = 1'b1;
        wait_n(busy_len);
        model_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (|gnt || tx_valid || |done || err) begin
        if (|gnt || tx_valid)
          act_ev = ev(cyc, 2'd1, oh2idx(gnt), tx_valid, tx_par_en, tx_par_typ, tx_data);
        else if (|done)
          act_ev = ev(cyc, 2'd2, oh2idx(done), 1'b0, 1'b0, 1'b0, 8'h00);
        else
          act_ev = ev(cyc, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %s, expected no event", ev_str(act_ev));
        end else begin
          exp_ev = exp_q.pop_front();
          if (act_ev !== exp_ev) begin
            n_fail++;
            $display("FAIL sb_event: got %s, expected %s", ev_str(act_ev), ev_str(exp_ev));
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (3000) @(posedge clk);
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete within 3000 cycles");
    summary();
    $finish;
  end

  // ---------------- directed stimulus ----------------
  int n;
  logic [7:0] b;

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    par_en_cfg = 1'b0;
    par_typ_cfg = 1'b0;
    force_busy = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    // Single frame from requester 0, parity on/odd; config changes mid-frame.
    wait_n(2);
    n = cyc;
    set_byte(0, 8'hCB);
    par_en_cfg = 1'b1;
    par_typ_cfg = 1'b1;
    req = 4'b0001;
    exp_q.push_back(ev(n + 1, 2'd1, 4'd0, 1'b1, 1'b1, 1'b1, 8'hCB));
    exp_q.push_back(ev(n + 14, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    check("s1_sched_busy_issue", 32'(sched_busy), 1);
    wait_n(4);
    par_en_cfg = 1'b0;
    par_typ_cfg = 1'b0;
    set_byte(0, 8'h00);
    wait_n(3);
    check("s1_hold_data",    32'(tx_data), 32'h0000_00CB);
    check("s1_hold_par_en",  32'(tx_par_en), 1);
    check("s1_hold_par_typ", 32'(tx_par_typ), 1);
    check("s1_state_wdone",  32'(dbg_state), 3);
    wait_n(6);
    check("s1_state_idle_at_done", 32'(dbg_state), 0);
    check("s1_sched_busy_idle",    32'(sched_busy), 0);
    wait_n(2);

    // All four request continuously: order 0,1,2,3,0.
    do_reset("rst1");
    n = cyc;
    for (int k = 0; k < NR; k++) set_byte(k, 8'h10 + 8'(k));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      b = 8'h10 + 8'(k % NR);
      exp_q.push_back(ev(n + 1 + 14 * k, 2'd1, 4'(k % NR), 1'b1, 1'b0, 1'b0, b));
      exp_q.push_back(ev(n + 14 + 14 * k, 2'd2, 4'(k % NR), 1'b0, 1'b0, 1'b0, 8'h00));
    end
    wait_n(57);
    req = '0;
    wait_n(14);

    // Serve requester 1 (pointer -> 2), then 0 and 1 compete: 0 wins by wrap.
    n = cyc;
    check("s3_ptr_start", 32'(dbg_ptr), 1);
    set_byte(1, 8'h21);
    req = 4'b0010;
    exp_q.push_back(ev(n + 1, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 8'h21));
    exp_q.push_back(ev(n + 14, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    wait_n(13);
    check("s3_ptr_after_r1", 32'(dbg_ptr), 2);
    set_byte(0, 8'h30);
    set_byte(1, 8'h31);
    req = 4'b0011;
    exp_q.push_back(ev(n + 15, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0, 8'h30));
    exp_q.push_back(ev(n + 28, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    check("s3_ptr_after_wrap", 32'(dbg_ptr), 1);
    wait_n(14);

    // Transmitter never acknowledges: ERR 4 cycles into WAIT_ACK, then recover.
    n = cyc;
    model_mode = 1;
    set_byte(2, 8'h42);
    req = 4'b0100;
    exp_q.push_back(ev(n + 1, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 8'h42));
    exp_q.push_back(ev(n + 6, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    wait_n(4);
    check("s4_state_wack", 32'(dbg_state), 2);
    wait_n(1);
    check("s4_state_idle_at_err", 32'(dbg_state), 0);
    model_mode = 0;
    set_byte(3, 8'h53);
    req = 4'b1000;
    exp_q.push_back(ev(n + 7, 2'd1, 4'd3, 1'b1, 1'b0, 1'b0, 8'h53));
    exp_q.push_back(ev(n + 20, 2'd2, 4'd3, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    wait_n(14);

    // TX_Busy already high in IDLE: no grant until it drops.
    n = cyc;
    force_busy = 1'b1;
    set_byte(2, 8'h66);
    par_en_cfg = 1'b1;
    par_typ_cfg = 1'b0;
    req = 4'b0100;
    wait_n(3);
    check("s5_state_held_idle", 32'(dbg_state), 0);
    check("s5_sched_busy_held", 32'(sched_busy), 0);
    wait_n(2);
    force_busy = 1'b0;
    exp_q.push_back(ev(n + 6, 2'd1, 4'd2, 1'b1, 1'b1, 1'b0, 8'h66));
    exp_q.push_back(ev(n + 19, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    wait_n(14);

    // Reset during WAIT_DONE abandons the frame; then a normal grant.
    n = cyc;
    par_en_cfg = 1'b0;
    set_byte(0, 8'h77);
    req = 4'b0001;
    exp_q.push_back(ev(n + 1, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0, 8'h77));
    wait_n(1);
    req = '0;
    wait_n(4);
    check("s6_state_wdone", 32'(dbg_state), 3);
    do_reset("rst_mid");
    wait_n(8);
    set_byte(1, 8'h88);
    req = 4'b0010;
    exp_q.push_back(ev(n + 15, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 8'h88));
    exp_q.push_back(ev(n + 28, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00));
    wait_n(1);
    req = '0;
    wait_n(16);

    check("sb_drain", 32'(exp_q.size()), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART_TX instance between NUM_REQ byte producers. It accepts one byte per grant and drives the UART_TX Data_Valid/P_DATA/PAR_EN/PAR_TYP inputs. It then tracks the transmitter's Busy output until the frame completes, reports per-requester completion, and flags a transmitter that never acknowledges. Sits between the control-system command sources and UART_TX.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width, matches UART_TX P_DATA
ACK_TIMEOUT, 4, cycles allowed in WAIT_ACK for TX_Busy to rise before ERR

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset; one clock; reset is synchronous and active-high
REQ  in  NUM_REQ  per-requester send request, level, held until GNT
REQ_DATA  in  NUM_REQ*DATA_WIDTH  byte of requester k at [k*DATA_WIDTH +: DATA_WIDTH]
PAR_EN_CFG  in  1  parity enable applied to the next issued frame
PAR_TYP_CFG  in  1  parity type, 0 even / 1 odd, applied to the next issued frame
GNT  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester k accepted
DONE  out  NUM_REQ  one-hot, one-cycle pulse: frame of requester k fully sent
ERR  out  1  one-cycle pulse: UART_TX did not raise Busy within ACK_TIMEOUT
TX_Data_Valid  out  1  to UART_TX Data_Valid
TX_P_DATA  out  DATA_WIDTH  to UART_TX P_DATA
TX_PAR_EN  out  1  to UART_TX PAR_EN
TX_PAR_TYP  out  1  to UART_TX PAR_TYP
TX_Busy  in  1  from UART_TX Busy
Sched_Busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset values: GNT=0, DONE=0, ERR=0, TX_Data_Valid=0, TX_P_DATA=0, TX_PAR_EN=0, TX_PAR_TYP=0, Sched_Busy=0, state=IDLE, rr pointer=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE -> ISSUE when |REQ and TX_Busy=0.
  - Winner: first set REQ bit scanning from the pointer upward, with wrap-around.
  - At this edge, latch REQ_DATA[winner] into TX_P_DATA and PAR_EN_CFG/PAR_TYP_CFG into TX_PAR_EN/TX_PAR_TYP.
  - Set pointer = (winner+1) mod NUM_REQ.
  - If TX_Busy=1 in IDLE, wait; no grant is issued.
- ISSUE, exactly 1 cycle: TX_Data_Valid=1, GNT[winner]=1, Sched_Busy=1; always -> WAIT_ACK.
- Latency: REQ sampled high in IDLE gives GNT/TX_Data_Valid on the next cycle.
- WAIT_ACK: TX_Data_Valid=0; counter increments each cycle.
  - TX_Busy=1 -> WAIT_DONE, counter cleared.
  - Counter reaching ACK_TIMEOUT with TX_Busy still 0 -> ERR pulse, no DONE, -> IDLE.
- WAIT_DONE: hold until TX_Busy=0, then DONE[winner]=1 for one cycle and -> IDLE.
- The next arbitration takes place in IDLE on the cycle after DONE. Minimum gap between frames is one IDLE cycle.
- TX_P_DATA and the parity outputs stay stable from ISSUE through WAIT_DONE. Config changes mid-frame take effect only at the next issue.
- Requester rules:
  - A requester must hold REQ and REQ_DATA stable until its GNT.
  - Dropping REQ before the IDLE->ISSUE edge withdraws the request.
  - Once the edge is taken, the frame is committed regardless of REQ.
- A requester that keeps REQ high after GNT is treated as a new request and competes again at the next IDLE.
- A requester that does not win is never starved: it wins within NUM_REQ frames.
- RST asserted in any state: next edge returns to reset values. An in-flight frame is abandoned with no DONE and no ERR.

Decomposition:
- Shared package uart_sched_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3), DATA_WIDTH default, ACK_TIMEOUT default.
- One sub-module, rr_arbiter:
  - inputs REQ, pointer; outputs one-hot winner, winner index, any-valid.
  - purely combinational; the pointer register stays in uart_tx_scheduler.

Test Plan:
- Reset then REQ=4'b0001, byte 8'hCB, PAR_EN_CFG=1, PAR_TYP_CFG=1, UART_TX model raising Busy 1 cycle after Data_Valid and holding it 11 cycles -> GNT[0] and TX_Data_Valid on cycle 1, TX_P_DATA=8'hCB, TX_PAR_EN=1, TX_PAR_TYP=1; DONE[0] one cycle after Busy falls; ERR never.
- REQ=4'b1111 held continuously with distinct bytes 8'h10..8'h13 -> grants in order 0,1,2,3,0; TX_P_DATA matches each winner's byte; exactly one GNT per frame.
- Pointer=2 (after serving requester 1), REQ=4'b0011 -> requester 0 wins (wrap-around), pointer becomes 1.
- UART_TX model never raises Busy -> ERR pulses exactly ACK_TIMEOUT=4 cycles after WAIT_ACK is entered, no DONE, state returns to IDLE and the next request is granted.
- TX_Busy held 1 while REQ=4'b0100 -> no GNT until Busy drops; GNT[2] arrives 1 cycle after.
- RST pulsed for 1 cycle during WAIT_DONE -> next cycle all outputs are at reset values, no DONE, pointer=0, then REQ=4'b0010 is granted normally.
